// File: rtl/gf8_serial_mult.sv
// Bit-serial GF(2^8) multiplier: MSB-first Horner iteration, one bit of b per clock,
// with valid/ready handshakes on operand and product sides.
module gf8_serial_mult #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] p,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_acc, r_a, r_b, r_p;
    logic [2:0] r_cnt;
    logic [7:0] w_xt, w_step;
    logic       w_load;

    // Reduction folded into every step so acc never leaves the field.
    assign w_xt   = {r_acc[6:0], 1'b0} ^ (r_acc[7] ? POLY : 8'h00);
    assign w_step = w_xt ^ (r_b[r_cnt] ? r_a : 8'h00);

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_load    = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign p         = r_p;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_load) w_state_nxt = RUN;
            RUN:  if (r_cnt == 3'd0) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = w_load ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= 8'h00;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_cnt   <= 3'd0;
            r_p     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= 8'h00;
                r_cnt <= 3'd7;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd0) r_p <= w_step;
            end
        end
    end

endmodule
